// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-Excess-3 converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam logic [3:0]  EX3_BIAS    = 4'd3;
    localparam logic [3:0]  EX3_INVALID = 4'h0;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } bcd_seq_state_t;

endpackage

// File: rtl/bcd_ex3_seq_if.sv
// Input/output handshake bundle for bcd_ex3_seq; master drives words in, slave is the converter.
interface bcd_ex3_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);

    logic                        in_valid;
    logic                        in_ready;
    logic [DIGIT_W*DIGITS-1:0]   in_bcd;
    logic                        out_valid;
    logic                        out_ready;
    logic [DIGIT_W*DIGITS-1:0]   out_ex3;
    logic [DIGITS-1:0]           out_err;
    logic                        busy;

    modport master (
        output in_valid,
        output in_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ex3,
        input  out_err,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ex3,
        output out_err,
        output busy
    );

endinterface

// File: rtl/bcd_digit_ex3.sv
// Single-digit BCD to Excess-3 converter; digits above 9 map to an illegal code and flag an error.
module bcd_digit_ex3
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] ex3,
    output logic       digit_err
);

    always_comb begin
        digit_err = (digit > BCD_MAX);
        ex3       = digit_err ? EX3_INVALID : (digit + EX3_BIAS);
    end

endmodule

// File: rtl/bcd_ex3_seq.sv
// Multi-digit BCD to Excess-3 converter: walks digits LSD first through one shared
// single-digit converter, one digit per clock, between two valid/ready handshakes.
module bcd_ex3_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    bcd_ex3_seq_if.slave bus
);

    localparam int unsigned DATA_W = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    bcd_seq_state_t    state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] src_q;
    logic [DATA_W-1:0] ex3_q;
    logic [DIGITS-1:0] err_q;

    logic [3:0] cur_digit;
    logic [3:0] cur_ex3;
    logic       cur_err;

    always_comb begin
        cur_digit = src_q[idx_q*DIGIT_W +: DIGIT_W];
    end

    bcd_digit_ex3 u_digit (
        .digit     (cur_digit),
        .ex3       (cur_ex3),
        .digit_err (cur_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            ex3_q   <= '0;
            err_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        src_q   <= bus.in_bcd;
                        ex3_q   <= '0;
                        err_q   <= '0;
                        idx_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    ex3_q[idx_q*DIGIT_W +: DIGIT_W] <= cur_ex3;
                    err_q[idx_q]                    <= cur_err;
                    // idx parks on the last digit; only an accept or reset returns it to 0
                    if (idx_q == IDX_LAST) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is masked by rst so nothing can be offered while reset is held
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_ex3   = ex3_q;
    assign bus.out_err   = err_q;

endmodule
